spi_xfer_sched: RTL and testbench

Round-robin scheduler that shares one `base_fsm` SPI read engine among `N_REQ` requesters. It grants one requester at a time and issues the single-cycle `start` pulse with a per-requester clock divider. It waits for the engine's `irq`, then returns the 12-bit sample tagged with the requester index. A watchdog aborts transfers whose `irq` never arrives.

---
 rtl/spi_xfer_sched_pkg.sv | 16 +
 rtl/spi_xfer_sched_rr_pick.sv | 52 +++++
 rtl/spi_xfer_sched.sv | 143 ++++++++++++++
 tb/tb_spi_xfer_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_xfer_sched_pkg.sv
// Shared types and widths for the SPI transfer scheduler.
// DIV_W matches the base_fsm clock-scaler width; SAMPLE_W is the ADC sample width.
package spi_xfer_sched_pkg;

  localparam int DIV_W    = 8;
  localparam int SAMPLE_W = 12;

  typedef enum logic [2:0] {
    SCH_IDLE  = 3'd0,
    SCH_START = 3'd1,
    SCH_BUSY  = 3'd2,
    SCH_DONE  = 3'd3,
    SCH_ERR   = 3'd4
  } sch_state_e;

endpackage

// File: rtl/spi_xfer_sched_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after the pointer,
// wrapping past the top. Returns both a one-hot vector and the index.
module rr_pick
  import spi_xfer_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_rr_ptr,
  output logic [N_REQ-1:0] o_pick_oh,
  output logic [ID_W-1:0]  o_pick_id,
  output logic             o_pick_vld
);

  localparam logic [ID_W:0] NREQ_L = (ID_W+1)'(N_REQ);

  logic [2*N_REQ-1:0] w_req2;
  logic [N_REQ-1:0]   w_rot;
  logic [ID_W:0]      w_off;
  logic [ID_W:0]      w_sum;
  logic [ID_W:0]      w_wrap;
  logic               w_vld;

  // Rotating a doubled copy puts the pointer position at bit 0.
  assign w_req2 = {i_req, i_req};
  assign w_rot  = w_req2[i_rr_ptr +: N_REQ];

  always_comb begin
    w_off = '0;
    w_vld = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = (ID_W+1)'(k);
        w_vld = 1'b1;
      end
    end
  end

  assign w_sum      = {1'b0, i_rr_ptr} + w_off;
  assign w_wrap     = (w_sum >= NREQ_L) ? (w_sum - NREQ_L) : w_sum;
  assign o_pick_id  = w_wrap[ID_W-1:0];
  assign o_pick_vld = w_vld;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_oh
      assign o_pick_oh[gi] = w_vld && (o_pick_id == ID_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/spi_xfer_sched.sv
// Round-robin scheduler sharing one base_fsm SPI read engine among N_REQ requesters,
// with irq rising-edge completion, a watchdog abort and tagged responses.
module spi_xfer_sched
  import spi_xfer_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int W     = DIV_W,
  parameter int TMO_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*W-1:0]  req_div,
  output logic [N_REQ-1:0]    gnt,
  output logic                rsp_valid,
  output logic [ID_W-1:0]     rsp_id,
  output logic [SAMPLE_W-1:0] rsp_data,
  output logic                rsp_err,
  output logic                fsm_start,
  output logic [W-1:0]        fsm_clk_scaler,
  input  logic                fsm_irq,
  input  logic [SAMPLE_W-1:0] fsm_data
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  sch_state_e          r_state;
  logic [N_REQ-1:0]    r_gnt;
  logic [ID_W-1:0]     r_cur_id;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [W-1:0]        r_scaler;
  logic                r_start;
  logic [TMO_W-1:0]    r_wdog;
  logic                r_irq_q;
  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic [SAMPLE_W-1:0] r_rsp_data;
  logic                r_rsp_err;

  logic [N_REQ-1:0]    w_pick_oh;
  logic [ID_W-1:0]     w_pick_id;
  logic                w_pick_vld;
  logic [W-1:0]        w_div_arr [N_REQ];
  logic                w_edge;
  logic                w_tmo;
  logic [ID_W-1:0]     w_next_ptr;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .i_req      (req),
    .i_rr_ptr   (r_rr_ptr),
    .o_pick_oh  (w_pick_oh),
    .o_pick_id  (w_pick_id),
    .o_pick_vld (w_pick_vld)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_div
      assign w_div_arr[gi] = req_div[gi*W +: W];
    end
  endgenerate

  // r_irq_q follows fsm_irq every cycle, so a level still high from an earlier
  // (or reset-abandoned) transfer must drop before it can count as completion.
  assign w_edge     = fsm_irq & ~r_irq_q;
  assign w_tmo      = &r_wdog;
  assign w_next_ptr = (r_cur_id == LAST_ID) ? '0 : r_cur_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SCH_IDLE;
      r_gnt       <= '0;
      r_cur_id    <= '0;
      r_rr_ptr    <= '0;
      r_scaler    <= '0;
      r_start     <= 1'b0;
      r_wdog      <= '0;
      r_irq_q     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_irq_q     <= fsm_irq;
      r_start     <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        SCH_IDLE: begin
          if (w_pick_vld) begin
            r_gnt    <= w_pick_oh;
            r_cur_id <= w_pick_id;
            r_scaler <= w_div_arr[w_pick_id];
            r_start  <= 1'b1;
            r_wdog   <= '0;
            r_state  <= SCH_START;
          end
        end
        SCH_START: begin
          r_wdog  <= r_wdog + 1'b1;
          r_state <= SCH_BUSY;
        end
        SCH_BUSY: begin
          // A completion edge takes priority over a watchdog expiring in the same cycle.
          if (w_edge) begin
            r_rsp_data  <= fsm_data;
            r_rsp_id    <= r_cur_id;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_gnt       <= '0;
            r_rr_ptr    <= w_next_ptr;
            r_state     <= SCH_DONE;
          end else if (w_tmo) begin
            r_rsp_data  <= '0;
            r_rsp_id    <= r_cur_id;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_gnt       <= '0;
            r_rr_ptr    <= w_next_ptr;
            r_state     <= SCH_ERR;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        SCH_DONE: r_state <= SCH_IDLE;
        SCH_ERR:  r_state <= SCH_IDLE;
        default:  r_state <= SCH_IDLE;
      endcase
    end
  end

  assign gnt            = r_gnt;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_id         = r_rsp_id;
  assign rsp_data       = r_rsp_data;
  assign rsp_err        = r_rsp_err;
  assign fsm_start      = r_start;
  assign fsm_clk_scaler = r_scaler;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Directed bench for spi_xfer_sched: instance A (default watchdog) and instance B
// (4-bit watchdog) with the base_fsm engine modelled by hand-driven irq/data.
module tb_spi_xfer_sched;
  import spi_xfer_sched_pkg::*;

  localparam int DW = DIV_W;

  logic clk = 1'b0;
  logic rst_n;

  logic [3:0]      req_a, req_b;
  logic [4*DW-1:0] div_a, div_b;
  logic            irq_a, irq_b;
  logic [11:0]     dat_a, dat_b;
  logic [3:0]      gnt_a, gnt_b;
  logic            vld_a, vld_b, err_a, err_b, start_a, start_b;
  logic [1:0]      id_a, id_b;
  logic [11:0]     rdat_a, rdat_b;
  logic [DW-1:0]   scl_a, scl_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_xfer_sched #(.N_REQ(4), .ID_W(2), .W(DW), .TMO_W(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .req_div(div_a), .gnt(gnt_a),
    .rsp_valid(vld_a), .rsp_id(id_a), .rsp_data(rdat_a), .rsp_err(err_a),
    .fsm_start(start_a), .fsm_clk_scaler(scl_a), .fsm_irq(irq_a), .fsm_data(dat_a)
  );

  spi_xfer_sched #(.N_REQ(4), .ID_W(2), .W(DW), .TMO_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .req_div(div_b), .gnt(gnt_b),
    .rsp_valid(vld_b), .rsp_id(id_b), .rsp_data(rdat_b), .rsp_err(err_b),
    .fsm_start(start_b), .fsm_clk_scaler(scl_b), .fsm_irq(irq_b), .fsm_data(dat_b)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start_a(input string tag);
    int n = 0;
    while (start_a !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    chk_val(tag, 32'(start_a), 32'd1);
  endtask

  task automatic wait_start_b(input string tag);
    int n = 0;
    while (start_b !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    chk_val(tag, 32'(start_b), 32'd1);
  endtask

  // One engine transfer on A: irq rises dly cycles after the start pulse.
  task automatic xfer_a(input int dly, input logic [11:0] data, input logic [1:0] exp_id);
    logic [3:0] oh;
    oh = 4'b0001 << exp_id;
    wait_start_a("fair_start");
    chk_val("fair_gnt", 32'(gnt_a), 32'(oh));
    repeat (dly) tick();
    irq_a = 1'b1;
    dat_a = data;
    tick();
    chk_val("fair_vld", 32'(vld_a), 32'd1);
    chk_val("fair_id", 32'(id_a), 32'(exp_id));
    chk_val("fair_data", 32'(rdat_a), 32'(data));
    $display("xfer A: id=%0d data=%03h err=%0d", id_a, rdat_a, err_a);
    irq_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int starts;
    int early;

    rst_n = 1'b0;
    req_a = '0; req_b = '0; div_a = '0; div_b = '0;
    irq_a = 1'b0; irq_b = 1'b0; dat_a = '0; dat_b = '0;
    tick();
    tick();
    chk_val("rst_gnt", 32'(gnt_a), 32'd0);
    chk_val("rst_vld", 32'(vld_a), 32'd0);
    chk_val("rst_id", 32'(id_a), 32'd0);
    chk_val("rst_data", 32'(rdat_a), 32'd0);
    chk_val("rst_err", 32'(err_a), 32'd0);
    chk_val("rst_start", 32'(start_a), 32'd0);
    chk_val("rst_scl", 32'(scl_a), 32'd0);
    chk_val("rst_vld_b", 32'(vld_b), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single requester; req and req_div change after grant and must not matter.
    req_a = 4'b0010;
    div_a = {8'd9, 8'd7, 8'd5, 8'd3};
    tick();
    chk_val("single_start", 32'(start_a), 32'd1);
    chk_val("single_gnt", 32'(gnt_a), 32'h2);
    chk_val("single_scl", 32'(scl_a), 32'd5);
    req_a = 4'b0000;
    div_a = {8'd9, 8'd7, 8'd66, 8'd3};
    starts = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (start_a) starts++;
    end
    chk_val("single_extra_start", 32'(starts), 32'd0);
    chk_val("single_gnt_held", 32'(gnt_a), 32'h2);
    chk_val("single_scl_held", 32'(scl_a), 32'd5);
    irq_a = 1'b1;
    dat_a = 12'hA5C;
    tick();
    chk_val("single_vld", 32'(vld_a), 32'd1);
    chk_val("single_id", 32'(id_a), 32'd1);
    chk_val("single_data", 32'(rdat_a), 32'hA5C);
    chk_val("single_err", 32'(err_a), 32'd0);
    chk_val("single_gnt_drop", 32'(gnt_a), 32'd0);
    $display("xfer A: id=%0d data=%03h err=%0d", id_a, rdat_a, err_a);
    irq_a = 1'b0;
    tick();
    chk_val("single_vld_pulse", 32'(vld_a), 32'd0);
    chk_val("single_data_hold", 32'(rdat_a), 32'hA5C);

    // Fairness from a fresh pointer.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    div_a = {8'd9, 8'd7, 8'd5, 8'd3};
    req_a = 4'b1111;
    for (int k = 0; k < 8; k++) xfer_a(5, 12'(k * 273 + 1), 2'(k % 4));

    // Stale irq held high from the previous transfer; pointer is now 0.
    req_a = 4'b0100;
    irq_a = 1'b1;
    wait_start_a("stale_start");
    early = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (vld_a) early++;
      if (i == 3) irq_a = 1'b0;
    end
    chk_val("stale_early", 32'(early), 32'd0);
    irq_a = 1'b1;
    dat_a = 12'h3C3;
    tick();
    chk_val("stale_vld", 32'(vld_a), 32'd1);
    chk_val("stale_id", 32'(id_a), 32'd2);
    chk_val("stale_data", 32'(rdat_a), 32'h3C3);
    $display("xfer A: id=%0d data=%03h err=%0d", id_a, rdat_a, err_a);
    irq_a = 1'b0;
    req_a = 4'b0000;

    // Instance B: irq edge exactly when the watchdog hits its maximum.
    req_b = 4'b0010;
    wait_start_b("simul_start");
    repeat (15) tick();
    irq_b = 1'b1;
    dat_b = 12'h5A5;
    tick();
    chk_val("simul_vld", 32'(vld_b), 32'd1);
    chk_val("simul_err", 32'(err_b), 32'd0);
    chk_val("simul_data", 32'(rdat_b), 32'h5A5);
    chk_val("simul_id", 32'(id_b), 32'd1);
    $display("xfer B: id=%0d data=%03h err=%0d", id_b, rdat_b, err_b);
    irq_b = 1'b0;

    // Instance B: no irq at all, watchdog abort 16 cycles after start.
    req_b = 4'b1111;
    wait_start_b("tmo_start");
    chk_val("tmo_gnt", 32'(gnt_b), 32'h4);
    early = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (vld_b) early++;
    end
    chk_val("tmo_early", 32'(early), 32'd0);
    tick();
    chk_val("tmo_vld", 32'(vld_b), 32'd1);
    chk_val("tmo_err", 32'(err_b), 32'd1);
    chk_val("tmo_data", 32'(rdat_b), 32'd0);
    chk_val("tmo_id", 32'(id_b), 32'd2);
    chk_val("tmo_gnt_drop", 32'(gnt_b), 32'd0);
    $display("xfer B: id=%0d data=%03h err=%0d", id_b, rdat_b, err_b);
    wait_start_b("tmo_next_start");
    chk_val("tmo_next_gnt", 32'(gnt_b), 32'h8);
    req_b = 4'b0000;

    // Reset mid-BUSY on A (pointer is 3 before reset), with a stale irq across it.
    req_a = 4'b1000;
    wait_start_a("rstm_start");
    chk_val("rstm_gnt_pre", 32'(gnt_a), 32'h8);
    repeat (5) tick();
    rst_n = 1'b0;
    irq_a = 1'b1;
    dat_a = 12'hFFF;
    #1;
    chk_val("rstm_gnt", 32'(gnt_a), 32'd0);
    chk_val("rstm_start0", 32'(start_a), 32'd0);
    chk_val("rstm_scl", 32'(scl_a), 32'd0);
    chk_val("rstm_id", 32'(id_a), 32'd0);
    chk_val("rstm_data", 32'(rdat_a), 32'd0);
    chk_val("rstm_err", 32'(err_a), 32'd0);
    early = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (vld_a) early++;
    end
    rst_n = 1'b1;
    req_a = 4'b1100;
    wait_start_a("rstm_restart");
    chk_val("rstm_regnt", 32'(gnt_a), 32'h4);
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (vld_a) early++;
      if (i == 3) irq_a = 1'b0;
    end
    chk_val("rstm_no_vld", 32'(early), 32'd0);
    irq_a = 1'b1;
    dat_a = 12'h123;
    tick();
    chk_val("rstm_vld", 32'(vld_a), 32'd1);
    chk_val("rstm_id2", 32'(id_a), 32'd2);
    chk_val("rstm_data2", 32'(rdat_a), 32'h123);
    $display("xfer A: id=%0d data=%03h err=%0d", id_a, rdat_a, err_a);
    irq_a = 1'b0;
    req_a = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
